// File: rtl/merge2_rr_arbiter.sv
// Two-input round-robin merge arbiter with a single-entry registered output stage.
// Optional per-input accept counters are enabled with `define MERGE2_GRANT_STATS_EN.
//
// state   | meaning
// EMPTY   | output stage holds nothing, Out_valid=0
// FULL    | output stage holds a flit, Out_valid=1
module merge2_rr_arbiter #(
  parameter int W         = 9,
  parameter bit INIT_LAST = 1'b1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] In0_data,
  input  logic         In0_valid,
  output logic         In0_ready,
  input  logic [W-1:0] In1_data,
  input  logic         In1_valid,
  output logic         In1_ready,
  output logic [W-1:0] Out_data,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic         Out_src
`ifdef MERGE2_GRANT_STATS_EN
  ,
  input  logic         Cnt_clr,
  output logic [15:0]  Cnt0,
  output logic [15:0]  Cnt1
`endif
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         src_q, src_d;
  logic         last_q, last_d;
  logic         free, grant, accept;

  always_comb begin
    free = (state_q == S_EMPTY) || Out_ready;
    if (In0_valid && In1_valid) grant = ~last_q;
    else                        grant = In1_valid;
    // Gating with RESET keeps both readies low while reset is asserted.
    accept  = free && (In0_valid || In1_valid) && !RESET;
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (accept) begin
      state_d = S_FULL;
      data_d  = grant ? In1_data : In0_data;
      src_d   = grant;
      last_d  = grant;
    end else if (Out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= INIT_LAST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign In0_ready = accept && !grant;
  assign In1_ready = accept && grant;
  assign Out_data  = data_q;
  assign Out_valid = (state_q == S_FULL);
  assign Out_src   = src_q;

`ifdef MERGE2_GRANT_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Clear has priority over a coinciding accept; counts saturate at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (Cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (accept) begin
      if (!grant && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      if (grant  && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign Cnt0 = cnt0_q;
  assign Cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_merge2_rr_arbiter.sv
// Self-checking bench for merge2_rr_arbiter: directed scenarios plus random traffic
// against a transaction-level model (last winner, held flit, accept counts).
module tb_merge2_rr_arbiter;
  localparam int W = 9;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] In0_data, In1_data;
  logic         In0_valid, In1_valid, Out_ready;
  logic         In0_ready, In1_ready;
  logic [W-1:0] Out_data;
  logic         Out_valid, Out_src;
`ifdef MERGE2_GRANT_STATS_EN
  logic         Cnt_clr = 1'b0;
  logic [15:0]  Cnt0, Cnt1;
`endif

  merge2_rr_arbiter #(.W(W), .INIT_LAST(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .In0_data(In0_data), .In0_valid(In0_valid), .In0_ready(In0_ready),
    .In1_data(In1_data), .In1_valid(In1_valid), .In1_ready(In1_ready),
    .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_src(Out_src)
`ifdef MERGE2_GRANT_STATS_EN
    , .Cnt_clr(Cnt_clr), .Cnt0(Cnt0), .Cnt1(Cnt1)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Model: whether a flit is held, what it is, who won last, accepts per input.
  int           m_full, m_src, m_last, m_cnt0, m_cnt1;
  logic [W-1:0] m_data;
  int           hold0, hold1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_src = 0; m_last = 1; m_data = '0; m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Entered just after a rising edge; consumes exactly one clock cycle.
  task automatic cycle(input logic v0, input logic [W-1:0] d0,
                       input logic v1, input logic [W-1:0] d1, input logic ordy);
    int g, acc;
    In0_valid = v0; In0_data = d0; In1_valid = v1; In1_data = d1; Out_ready = ordy;
    #1;
    g   = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
    acc = ((m_full == 0) || ordy) && (v0 || v1);
    chk("rdy0", 32'(In0_ready), 32'(acc != 0 && g == 0));
    chk("rdy1", 32'(In1_ready), 32'(acc != 0 && g == 1));
    hold0 = (v0 && !(acc != 0 && g == 0)) ? 1 : 0;
    hold1 = (v1 && !(acc != 0 && g == 1)) ? 1 : 0;
    @(posedge CLK);
    #1;
    if (acc != 0) begin
      m_full = 1; m_src = g; m_last = g; m_data = (g == 1) ? d1 : d0;
      if (g == 0) m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : 65535;
      else        m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;
    end else if (ordy) begin
      m_full = 0;
    end
`ifdef MERGE2_GRANT_STATS_EN
    if (Cnt_clr) begin m_cnt0 = 0; m_cnt1 = 0; end
    chk("cnt0", 32'(Cnt0), 32'(m_cnt0));
    chk("cnt1", 32'(Cnt1), 32'(m_cnt1));
`endif
    chk("ovalid", 32'(Out_valid), 32'(m_full));
    if (m_full != 0) begin
      chk("odata", 32'(Out_data), 32'(m_data));
      chk("osrc", 32'(Out_src), 32'(m_src));
    end
  endtask

  // Asserts reset between edges with both inputs requesting, holds it one edge.
  task automatic do_reset();
    In0_valid = 1'b1; In1_valid = 1'b1; Out_ready = 1'b1;
    RESET = 1'b1;
    #1;
    chk("rst_ovalid", 32'(Out_valid), 32'd0);
    chk("rst_odata", 32'(Out_data), 32'd0);
    chk("rst_osrc", 32'(Out_src), 32'd0);
    chk("rst_rdy0", 32'(In0_ready), 32'd0);
    chk("rst_rdy1", 32'(In1_ready), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    chk("rst_hold_ovalid", 32'(Out_valid), 32'd0);
    RESET = 1'b0;
  endtask

  initial begin
    logic         v0, v1, r;
    logic [W-1:0] d0, d1;
    RESET = 1'b1; In0_valid = 0; In1_valid = 0; In0_data = '0; In1_data = '0; Out_ready = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Reset mid-run with a flit held, then first contention goes to In0.
    cycle(1'b1, 9'h0F0, 1'b0, 9'h000, 1'b0);
    chk("pre_rst_full", 32'(Out_valid), 32'd1);
    do_reset();
    In0_valid = 1; In0_data = 9'h0A0; In1_valid = 1; In1_data = 9'h140; Out_ready = 1;
    #1;
    chk("first_rdy0", 32'(In0_ready), 32'd1);
    cycle(1'b1, 9'h0A0, 1'b1, 9'h140, 1'b1);
    chk("first_data", 32'(Out_data), 32'h0A0);
    chk("first_src", 32'(Out_src), 32'd0);

    // Alternation from a fresh reset: 0,1,0,1,0,1 with no bubbles.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 9'(16 + i), 1'b1, 9'(32 + i), 1'b1);
      chk("alt_src", 32'(Out_src), 32'(i % 2));
      chk("alt_valid", 32'(Out_valid), 32'd1);
    end
`ifdef MERGE2_GRANT_STATS_EN
    chk("stat_cnt0", 32'(Cnt0), 32'd3);
    chk("stat_cnt1", 32'(Cnt1), 32'd3);
    Cnt_clr = 1'b1;
    cycle(1'b1, 9'h011, 1'b1, 9'h022, 1'b1);
    Cnt_clr = 1'b0;
    chk("clr_cnt0", 32'(Cnt0), 32'd0);
    chk("clr_cnt1", 32'(Cnt1), 32'd0);
`endif

    // Backpressure: 9'h155 held for 4 stalled cycles, then opposite input wins.
    cycle(1'b1, 9'h155, 1'b0, 9'h000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 9'h0AA, 1'b1, 9'h0BB, 1'b0);
      chk("bp_data", 32'(Out_data), 32'h155);
    end
    In0_valid = 1; In1_valid = 1; Out_ready = 1;
    #1;
    chk("bp_release_rdy1", 32'(In1_ready), 32'd1);
    cycle(1'b1, 9'h0AA, 1'b1, 9'h0BB, 1'b1);
    chk("bp_release_data", 32'(Out_data), 32'h0BB);

    // Single requester back-to-back, then contention goes to In0.
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 9'h000, 1'b1, 9'(k), 1'b1);
      chk("single_src", 32'(Out_src), 32'd1);
      chk("single_data", 32'(Out_data), 32'(k));
    end
    In0_valid = 1; In1_valid = 1; Out_ready = 1;
    #1;
    chk("single_then_rdy0", 32'(In0_ready), 32'd1);
    cycle(1'b1, 9'h0C1, 1'b1, 9'h0C2, 1'b1);

    // Drain: Out_valid drops, and the pointer stays on In0 so In1 wins next.
    cycle(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    chk("drain_valid", 32'(Out_valid), 32'd0);
    cycle(1'b0, 9'h000, 1'b0, 9'h000, 1'b1);
    In0_valid = 1; In1_valid = 1; Out_ready = 1;
    #1;
    chk("drain_then_rdy1", 32'(In1_ready), 32'd1);
    cycle(1'b1, 9'h0D1, 1'b1, 9'h0D2, 1'b1);

    // Random traffic honouring the hold-while-stalled rule.
    hold0 = 0; hold1 = 0;
    d0 = '0; d1 = '0; v0 = 0; v1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold0 == 0) begin v0 = 1'($urandom_range(0, 1)); d0 = 9'($urandom); end
      if (hold1 == 0) begin v1 = 1'($urandom_range(0, 1)); d1 = 9'($urandom); end
      r = ($urandom_range(0, 3) != 0);
      cycle(v0, d0, v1, d1, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/merge2_rr_arbiter.md
Name: merge2_rr_arbiter

Overview:
- Two-input round-robin merge arbiter for the tree NoC; the upstream counterpart of the 1-to-2 address decoder/splitter.
- Shares one output channel between two packet requesters, e.g. the local port and the child subtree.
- Registers the winning flit in a single-entry output stage and reports which input won.
- Packet format matches the decoder: W-bit flit with destination address in bits [8:5].

Parameters:
- W, 9, flit width in bits (must be >= 9 so the address field [8:5] exists).
- INIT_LAST, 1, value of the last-grant pointer after reset (1 means In0 wins the first contention).

Ports:
- CLK  input  1  single clock, rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- In0_data  input  W  flit from requester 0.
- In0_valid  input  1  requester 0 has a flit.
- In0_ready  output  1  requester 0 flit accepted this cycle when In0_valid && In0_ready.
- In1_data  input  W  flit from requester 1.
- In1_valid  input  1  requester 1 has a flit.
- In1_ready  output  1  requester 1 flit accepted this cycle when In1_valid && In1_ready.
- Out_data  output  W  registered winning flit.
- Out_valid  output  1  Out_data/Out_src hold a flit.
- Out_ready  input  1  downstream accepts when Out_valid && Out_ready.
- Out_src  output  1  index of the input that supplied Out_data.

Behaviour:
- Reset (RESET=1, async): Out_valid=0, Out_data=0, Out_src=0, last=INIT_LAST. In0_ready=In1_ready=0 while RESET is high. A flit in flight is discarded, and no partial handshake completes on the reset edge.
- Output stage FSM, two states:
  - EMPTY (Out_valid=0).
  - FULL (Out_valid=1).
- Stage is free when state==EMPTY or Out_ready==1.
- Grant, combinational each cycle:
  - Only In0_valid -> g=0.
  - Only In1_valid -> g=1.
  - Both valid -> g = ~last.
  - Neither -> no grant.
- In<g>_ready = free && In<g>_valid. The non-granted ready is 0. At most one ready is high per cycle.
- On accept at edge t: Out_data<=In<g>_data, Out_src<=g, last<=g, state->FULL. Out_valid is high from cycle t+1, so latency is 1 cycle.
- FULL && Out_ready && no accept -> EMPTY.
- FULL && Out_ready && accept -> stays FULL and loads the new flit. Sustained throughput is 1 flit/cycle.
- FULL && !Out_ready: Out_data and Out_src are held stable, both readies are 0, and last is unchanged.
- last changes only on an accept, never on stalls or idle cycles.
- Fairness: with both inputs continuously valid and Out_ready=1, grants alternate 0,1,0,1…. A waiting requester is served within 2 accepts.
- Flit contents pass through unmodified; no width arithmetic.
- Inputs must hold data stable while valid && !ready. The arbiter does not check this.

Optional Feature:
- Macro MERGE2_GRANT_STATS_EN.
- When defined:
  - Adds outputs Cnt0 and Cnt1, 16 bits each, counting accepts per input.
  - Counters reset to 0 and saturate at 16'hFFFF.
  - Adds input Cnt_clr, which synchronously zeroes both counters. If Cnt_clr coincides with an accept, the counter ends at 0.
- When not defined: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset/first contention: assert RESET mid-run with Out_valid=1, then release. Required: Out_valid=0 immediately. Then In0=9'h0A0 and In1=9'h140 both valid, Out_ready=1. Required: In0_ready=1, next cycle Out_data=9'h0A0 and Out_src=0.
- Alternation: both inputs always valid, Out_ready=1 for 6 cycles. Required: Out_src sequence 0,1,0,1,0,1, one flit per cycle, no bubbles.
- Backpressure: FULL with Out_data=9'h155, Out_ready=0 for 4 cycles, both inputs valid. Required: Out_data stays 9'h155 and both readies are 0. Out_ready=1 then grants the opposite input of Out_src.
- Single requester: only In1 valid with flits 9'h001, 9'h002, 9'h003, Out_ready=1. Required: all three accepted back-to-back and Out_src=1 each time. A later contention grants In0.
- Drain: one flit, then both inputs idle and Out_ready=1. Required: Out_valid drops to 0 one cycle after the handshake, and last is unchanged.
- Stats (MERGE2_GRANT_STATS_EN): after the alternation test, Cnt0=3 and Cnt1=3. Pulse Cnt_clr during an accept: both counters read 0 the next cycle.
